// File: rtl/wb_regfile_pkg.sv
// Shared write-back definitions: source-select encodings, datapath widths and
// the destination-field extractor, also used by the forwarding unit.
package wb_regfile_pkg;

  localparam int DATA_W   = 8;
  localparam int INSTR_W  = 19;
  localparam int REG_CNT  = 8;
  localparam int ADDR_W   = 3;
  localparam int DEST_LSB = 11;

  localparam logic [1:0] WB_SRC_NONE  = 2'b00;
  localparam logic [1:0] WB_SRC_ALU   = 2'b01;
  localparam logic [1:0] WB_SRC_MEM   = 2'b10;
  localparam logic [1:0] WB_SRC_SHIFT = 2'b11;

  function automatic logic [ADDR_W-1:0] get_dest(input logic [INSTR_W-1:0] instr);
    return instr[DEST_LSB+ADDR_W-1:DEST_LSB];
  endfunction

endpackage

// File: rtl/wb_regfile_src_mux.sv
// wb_src_mux: combinational write-back source select and write-enable.
// Zero latency; no flow control (pure combinational).
module wb_src_mux
  import wb_regfile_pkg::*;
(
  input  logic [1:0]        sel,
  input  logic [DATA_W-1:0] alu,
  input  logic [DATA_W-1:0] mem,
  input  logic [DATA_W-1:0] shift,
  input  logic [ADDR_W-1:0] dest,
  output logic [DATA_W-1:0] value,
  output logic              we
);

  always_comb begin
    value = '0;
    unique case (sel)
      WB_SRC_ALU:   value = alu;
      WB_SRC_MEM:   value = mem;
      WB_SRC_SHIFT: value = shift;
      default:      value = '0;
    endcase
  end

  // R0 is hardwired to zero, so a write aimed at it is not a write at all.
  assign we = (sel != WB_SRC_NONE) && (dest != '0);

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage + 8x8 register file; commit on the clock edge, reads combinational.
// WB_REGFILE_BYPASS_EN enables same-cycle write-through on the read ports; no backpressure.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  MEM_WB_mem_out_data,
  input  logic [DATA_W-1:0]  MEM_WB_alu_out,
  input  logic [DATA_W-1:0]  MEM_WB_shift_out,
  input  logic [INSTR_W-1:0] MEM_WB_instruction,
  input  logic [1:0]         MEM_WB_reg_write_mux,
  input  logic [ADDR_W-1:0]  rd_addr_a,
  input  logic [ADDR_W-1:0]  rd_addr_b,
  output logic [DATA_W-1:0]  rd_data_a,
  output logic [DATA_W-1:0]  rd_data_b,
  output logic               wb_valid,
  output logic [ADDR_W-1:0]  wb_dest,
  output logic [DATA_W-1:0]  wb_data,
  output logic [CNT_W-1:0]   retire_cnt
);

  logic [DATA_W-1:0] regs [REG_CNT];
  logic [ADDR_W-1:0] dest;
  logic [DATA_W-1:0] value;
  logic              we;
  logic              unused_instr;

  assign dest = get_dest(MEM_WB_instruction);
  assign unused_instr = ^{MEM_WB_instruction[INSTR_W-1:DEST_LSB+ADDR_W],
                          MEM_WB_instruction[DEST_LSB-1:0]};

  wb_src_mux u_src_mux (
    .sel   (MEM_WB_reg_write_mux),
    .alu   (MEM_WB_alu_out),
    .mem   (MEM_WB_mem_out_data),
    .shift (MEM_WB_shift_out),
    .dest  (dest),
    .value (value),
    .we    (we)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_CNT; i++) regs[i] <= '0;
      wb_valid   <= 1'b0;
      wb_dest    <= '0;
      wb_data    <= '0;
      retire_cnt <= '0;
    end else begin
      wb_valid <= we;
      if (we) begin
        regs[dest] <= value;
        wb_dest    <= dest;
        wb_data    <= value;
        retire_cnt <= retire_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    rd_data_a = (rd_addr_a == '0) ? '0 : regs[rd_addr_a];
    rd_data_b = (rd_addr_b == '0) ? '0 : regs[rd_addr_b];
`ifdef WB_REGFILE_BYPASS_EN
    // we already excludes R0, so the write-through can never unzero it.
    if (we && (rd_addr_a == dest)) rd_data_a = value;
    if (we && (rd_addr_b == dest)) rd_data_b = value;
`endif
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: reference model of the register file plus directed vectors.
module tb_wb_regfile;

  logic        clk;
  logic        reset;
  logic [7:0]  mem_d, alu_d, shf_d;
  logic [18:0] instr;
  logic [1:0]  sel;
  logic [2:0]  ra, rb;
  logic [7:0]  rda, rdb, wdat, rda4, rdb4, wdat4;
  logic        wval, wval4;
  logic [2:0]  wdst, wdst4;
  logic [15:0] rcnt;
  logic [3:0]  rcnt4;

  int checks = 0;
  int errors = 0;

  wb_regfile dut (
    .clk(clk), .reset(reset),
    .MEM_WB_mem_out_data(mem_d), .MEM_WB_alu_out(alu_d), .MEM_WB_shift_out(shf_d),
    .MEM_WB_instruction(instr), .MEM_WB_reg_write_mux(sel),
    .rd_addr_a(ra), .rd_addr_b(rb), .rd_data_a(rda), .rd_data_b(rdb),
    .wb_valid(wval), .wb_dest(wdst), .wb_data(wdat), .retire_cnt(rcnt)
  );

  wb_regfile #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset),
    .MEM_WB_mem_out_data(mem_d), .MEM_WB_alu_out(alu_d), .MEM_WB_shift_out(shf_d),
    .MEM_WB_instruction(instr), .MEM_WB_reg_write_mux(sel),
    .rd_addr_a(ra), .rd_addr_b(rb), .rd_data_a(rda4), .rd_data_b(rdb4),
    .wb_valid(wval4), .wb_dest(wdst4), .wb_data(wdat4), .retire_cnt(rcnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural register contents and retirement history.
  logic [7:0] mreg [8];
  logic       mvalid = 1'b0;
  logic [2:0] mdest  = 3'd0;
  logic [7:0] mdata  = 8'd0;
  int         mcnt   = 0;

  initial for (int i = 0; i < 8; i++) mreg[i] = 8'd0;

  function automatic logic [7:0] src_val();
    case (sel)
      2'b01:   return alu_d;
      2'b10:   return mem_d;
      default: return shf_d;
    endcase
  endfunction

  function automatic logic model_we();
    if (sel === 2'b00) return 1'b0;
    return instr[13:11] != 3'd0;
  endfunction

  function automatic logic [7:0] exp_rd(input logic [2:0] a);
    if (a == 3'd0) return 8'd0;
`ifdef WB_REGFILE_BYPASS_EN
    if (model_we() && instr[13:11] == a) return src_val();
`endif
    return mreg[a];
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) mreg[i] = 8'd0;
      mvalid = 1'b0; mdest = 3'd0; mdata = 8'd0; mcnt = 0;
    end else begin
      mvalid = model_we();
      if (mvalid) begin
        mdest = instr[13:11];
        mdata = src_val();
        mreg[mdest] = mdata;
        mcnt = mcnt + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("rd_a", {24'd0, rda}, {24'd0, exp_rd(ra)});
    chk("rd_b", {24'd0, rdb}, {24'd0, exp_rd(rb)});
    chk("wb_valid", {31'd0, wval}, {31'd0, mvalid});
    chk("wb_dest", {29'd0, wdst}, {29'd0, mdest});
    chk("wb_data", {24'd0, wdat}, {24'd0, mdata});
    chk("retire_cnt", {16'd0, rcnt}, mcnt & 32'hFFFF);
    chk("retire_cnt4", {28'd0, rcnt4}, mcnt & 32'hF);
  end

  task automatic set_in(input logic [1:0] s, input logic [7:0] v, input logic [2:0] d);
    sel   = s;
    alu_d = (s == 2'b01) ? v : ~v;
    mem_d = (s == 2'b10) ? v : ~v;
    shf_d = (s == 2'b11) ? v : ~v;
    instr = {5'h15, d, 11'h2A5};
  endtask

  task automatic cyc(input logic [1:0] s, input logic [7:0] v, input logic [2:0] d);
    set_in(s, v, d);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    ra = 3'd0; rb = 3'd0;
    set_in(2'b00, 8'h00, 3'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, wval}, 32'd0);
    chk("rst_cnt", {16'd0, rcnt}, 32'd0);
    reset = 1'b1;

    // Each source once into R3..R5.
    cyc(2'b01, 8'h3C, 3'd3);
    cyc(2'b10, 8'hA5, 3'd4);
    cyc(2'b11, 8'h81, 3'd5);
    set_in(2'b00, 8'h00, 3'd0);
    ra = 3'd3; rb = 3'd4; #1;
    chk("r3", {24'd0, rda}, 32'h3C);
    chk("r4", {24'd0, rdb}, 32'hA5);
    ra = 3'd5; #1;
    chk("r5", {24'd0, rda}, 32'h81);
    chk("cnt3", {16'd0, rcnt}, 32'd3);
    chk("dest5", {29'd0, wdst}, 32'd5);
    chk("data81", {24'd0, wdat}, 32'h81);
    @(posedge clk); #1;

    // No-write, write to R0, and unknown inputs with no source selected.
    ra = 3'd2; rb = 3'd0;
    cyc(2'b00, 8'hFF, 3'd2);
    chk("nowr_valid", {31'd0, wval}, 32'd0);
    cyc(2'b01, 8'h77, 3'd0);
    chk("r0wr_valid", {31'd0, wval}, 32'd0);
    chk("r2_kept", {24'd0, rda}, 32'd0);
    chk("r0_zero", {24'd0, rdb}, 32'd0);
    sel = 2'b00; alu_d = 'x; mem_d = 'x; shf_d = 'x; instr = 'x;
    @(posedge clk); #1;
    chk("x_cnt", {16'd0, rcnt}, 32'd3);
    chk("x_data", {24'd0, wdat}, 32'h81);

    // Same-cycle read of the write target.
    ra = 3'd6; rb = 3'd6;
    set_in(2'b01, 8'h5A, 3'd6);
    #1;
`ifdef WB_REGFILE_BYPASS_EN
    chk("bypass_same", {24'd0, rda}, 32'h5A);
`else
    chk("nobypass_same", {24'd0, rda}, 32'h00);
`endif
    @(posedge clk); #1;
    chk("r6_after", {24'd0, rda}, 32'h5A);

    // Back-to-back overwrite with both ports on the same register.
    ra = 3'd7; rb = 3'd7;
    cyc(2'b01, 8'h11, 3'd7);
    cyc(2'b10, 8'h22, 3'd7);
    set_in(2'b00, 8'h00, 3'd0);
    #1;
    chk("r7_a", {24'd0, rda}, 32'h22);
    chk("r7_b", {24'd0, rdb}, 32'h22);
    chk("cnt6", {16'd0, rcnt}, 32'd6);

    // 11 more writes: 17 total, so the 4-bit counter has wrapped to 1.
    ra = 3'd1; rb = 3'd7;
    for (int i = 0; i < 11; i++) cyc(2'b11, 8'h40 + 8'(i), 3'(1 + (i % 7)));
    set_in(2'b00, 8'h00, 3'd0);
    #1;
    chk("cnt17", {16'd0, rcnt}, 32'd17);
    chk("cnt4_wrap", {28'd0, rcnt4}, 32'd1);
    chk("r1_last", {24'd0, rda}, 32'h47);

    // Asynchronous reset in the middle of a pending write.
    @(posedge clk); #1;
    set_in(2'b01, 8'hEE, 3'd7);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_rd_a", {24'd0, rda}, 32'd0);
    chk("arst_rd_b", {24'd0, rdb}, 32'd0);
    chk("arst_valid", {31'd0, wval}, 32'd0);
    chk("arst_cnt", {16'd0, rcnt}, 32'd0);
    chk("arst_data", {24'd0, wdat}, 32'd0);
    @(posedge clk); #1;
    set_in(2'b00, 8'h00, 3'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_r7", {24'd0, rdb}, 32'd0);
    chk("post_rst_cnt", {16'd0, rcnt}, 32'd0);

    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
